// File: rtl/motion_arbiter.sv
// ============================================================================
// motion_arbiter: grants one motion requester at a time to Motion_Commands.
// Optional escape preemption via MOTION_ARB_PREEMPT_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module motion_arbiter #(
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] req_i,
    input  logic [9:0] cmd0_i,
    input  logic [9:0] cmd1_i,
    input  logic [9:0] cmd2_i,
    input  logic [2:0] spd0_i,
    input  logic [2:0] spd1_i,
    input  logic [2:0] spd2_i,
    input  logic       done_spin_i,
    output logic [2:0] gnt_o,
    output logic [2:0] ack_o,
    output logic [9:0] motion_command_o,
    output logic [2:0] motion_speed_o,
    output logic       busy_o,
    output logic       timeout_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [15:0] C_WDOG_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  C_GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t      state_q;
    logic [2:0]  gnt_q;
    logic [2:0]  ack_q;
    logic [9:0]  cmd_q;
    logic [2:0]  spd_q;
    logic        busy_q;
    logic        timeout_err_q;
    logic        rr_last_q;     // 1: random was the last non-escape winner
    logic [15:0] wdog_q;
    logic [3:0]  gap_q;

    logic [2:0]  win_d;
    logic [9:0]  win_cmd_d;
    logic [2:0]  win_spd_d;
    logic        preempt_d;
    logic        withdraw_d;

    always_comb begin
        win_d     = 3'b000;
        win_cmd_d = 10'd0;
        win_spd_d = 3'd0;
        if (req_i[0]) begin
            win_d = 3'b001;
        end else if (req_i[1] && req_i[2]) begin
            win_d = rr_last_q ? 3'b010 : 3'b100;
        end else if (req_i[1]) begin
            win_d = 3'b010;
        end else if (req_i[2]) begin
            win_d = 3'b100;
        end
        case (win_d)
            3'b001:  begin win_cmd_d = cmd0_i; win_spd_d = spd0_i; end
            3'b010:  begin win_cmd_d = cmd1_i; win_spd_d = spd1_i; end
            3'b100:  begin win_cmd_d = cmd2_i; win_spd_d = spd2_i; end
            default: begin win_cmd_d = 10'd0;  win_spd_d = 3'd0;   end
        endcase
    end

`ifdef MOTION_ARB_PREEMPT_EN
    assign preempt_d = req_i[0] && !gnt_q[0];
`else
    assign preempt_d = 1'b0;
`endif

    assign withdraw_d = ((req_i & gnt_q) == 3'b000);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            gnt_q         <= 3'b000;
            ack_q         <= 3'b000;
            cmd_q         <= 10'd0;
            spd_q         <= 3'd0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            rr_last_q     <= 1'b1;
            wdog_q        <= 16'd0;
            gap_q         <= 4'd0;
        end else begin
            ack_q         <= 3'b000;
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_d != 3'b000) begin
                        gnt_q   <= win_d;
                        cmd_q   <= win_cmd_d;
                        spd_q   <= win_spd_d;
                        busy_q  <= 1'b1;
                        wdog_q  <= 16'd0;
                        state_q <= ST_DRIVE;
                        if (!win_d[0]) begin
                            rr_last_q <= win_d[2];
                        end
                    end
                end
                ST_DRIVE: begin
                    // Exit order: completion, preemption, withdrawal, watchdog.
                    if (done_spin_i || preempt_d || withdraw_d || (wdog_q == C_WDOG_LAST)) begin
                        if (done_spin_i) begin
                            ack_q <= gnt_q;
                        end else if (!preempt_d && !withdraw_d) begin
                            timeout_err_q <= 1'b1;
                        end
                        gnt_q   <= 3'b000;
                        cmd_q   <= 10'd0;
                        spd_q   <= 3'd0;
                        gap_q   <= 4'd0;
                        state_q <= ST_GAP;
                    end else if (wdog_q != 16'hFFFF) begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == C_GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o            = gnt_q;
    assign ack_o            = ack_q;
    assign motion_command_o = cmd_q;
    assign motion_speed_o   = spd_q;
    assign busy_o           = busy_q;
    assign timeout_err_o    = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_motion_arbiter.sv
// Testbench for motion_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a grant-level behavioural model.
`default_nettype none

module tb_motion_arbiter;

    localparam int TO  = 16;
    localparam int GAP = 2;
`ifdef MOTION_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [9:0] cmd0, cmd1, cmd2;
    logic [2:0] spd0, spd1, spd2;
    logic       done;
    logic [2:0] gnt, ack;
    logic [9:0] mcmd;
    logic [2:0] mspd;
    logic       busy, terr;

    int vectors = 0;
    int miscompares = 0;

    motion_arbiter #(.TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .cmd0_i(cmd0), .cmd1_i(cmd1), .cmd2_i(cmd2),
        .spd0_i(spd0), .spd1_i(spd1), .spd2_i(spd2),
        .done_spin_i(done),
        .gnt_o(gnt), .ack_o(ack), .motion_command_o(mcmd),
        .motion_speed_o(mspd), .busy_o(busy), .timeout_err_o(terr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: who owns the datapath, for how long, and how much gap is left.
    int         owner = -1;
    int         age = 0;
    int         gap_left = 0;
    bit         rr_random_last = 1'b1;
    logic [9:0] lat_cmd = '0;
    logic [2:0] lat_spd = '0;
    logic [2:0] m_ack = '0;
    logic       m_to = 1'b0;

    task automatic end_grant();
        owner    = -1;
        gap_left = GAP;
    endtask

    task automatic model_step();
        logic [9:0] cmds [3];
        logic [2:0] spds [3];
        int w;
        cmds = '{cmd0, cmd1, cmd2};
        spds = '{spd0, spd1, spd2};
        m_ack = '0;
        m_to  = 1'b0;
        if (rst) begin
            owner = -1; age = 0; gap_left = 0; rr_random_last = 1'b1;
            return;
        end
        if (owner >= 0) begin
            age++;
            if (done) begin
                m_ack[owner] = 1'b1;
                end_grant();
            end else if (PREEMPT && owner != 0 && req[0]) begin
                end_grant();
            end else if (!req[owner]) begin
                end_grant();
            end else if (age == TO) begin
                m_to = 1'b1;
                end_grant();
            end
        end else if (gap_left > 0) begin
            gap_left--;
        end else begin
            if (req[0])               w = 0;
            else if (req[1] && req[2]) w = rr_random_last ? 1 : 2;
            else if (req[1])          w = 1;
            else if (req[2])          w = 2;
            else                      w = -1;
            if (w >= 0) begin
                owner   = w;
                age     = 0;
                lat_cmd = cmds[w];
                lat_spd = spds[w];
                if (w != 0) rr_random_last = (w == 2);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
            chk("gnt", gnt, (owner >= 0) ? (32'd1 << owner) : 32'd0);
            chk("ack", ack, m_ack);
            chk("cmd", mcmd, (owner >= 0) ? lat_cmd : 10'd0);
            chk("spd", mspd, (owner >= 0) ? lat_spd : 3'd0);
            chk("busy", busy, (owner >= 0 || gap_left > 0));
            chk("timeout_err", terr, m_to);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 50; i++) begin
            if (gnt != 3'b000) return;
            tick();
        end
        chk("wait_gnt_bound", gnt != 3'b000, 1);
    endtask

    logic [2:0] rr_exp [3] = '{3'b010, 3'b100, 3'b010};

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;
        cmd0 = '0; cmd1 = '0; cmd2 = '0; spd0 = '0; spd1 = '0; spd2 = '0;
        repeat (3) tick();
        chk("reset_gnt", gnt, 3'b000);
        chk("reset_busy", busy, 1'b0);

        // Reset in the middle of a spiral grant.
        rst = 1'b0; cmd1 = 10'h155; spd1 = 3'd5; req = 3'b010;
        tick();
        chk("spiral_gnt", gnt, 3'b010);
        chk("spiral_cmd", mcmd, 10'h155);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gnt", gnt, 3'b000);
        chk("async_rst_cmd", mcmd, 10'd0);
        chk("async_rst_spd", mspd, 3'd0);
        chk("async_rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0; req = 3'b110;
        tick();
        chk("first_tie_gnt", gnt, 3'b010);

        // Round-robin between spiral and random, 5-cycle drives.
        for (int g = 0; g < 3; g++) begin
            wait_gnt();
            chk("rr_gnt", gnt, rr_exp[g]);
            repeat (4) tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("rr_ack", ack, rr_exp[g]);
            chk("rr_stop", mcmd, 10'd0);
            tick();
            chk("rr_gap_busy", busy, 1'b1);
            tick();
            chk("rr_gap_end", busy, 1'b0);
        end

        // Escape priority.
        req = 3'b111; cmd0 = 10'h3C1; spd0 = 3'd3;
        tick();
        chk("prio_gnt", gnt, 3'b001);
        chk("prio_cmd", mcmd, 10'h3C1);
        chk("prio_spd", mspd, 3'd3);
        repeat (2) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("prio_ack", ack, 3'b001);
        req = 3'b000;
        repeat (4) tick();

        // Watchdog timeout.
        req = 3'b010;
        wait_gnt();
        repeat (TO - 1) tick();
        chk("to_early", terr, 1'b0);
        tick();
        chk("to_pulse", terr, 1'b1);
        chk("to_ack", ack, 3'b000);
        chk("to_cmd", mcmd, 10'd0);
        req = 3'b000;
        repeat (4) tick();

        // Escape arriving during a random grant.
        req = 3'b100; cmd2 = 10'h2AA; spd2 = 3'd1;
        wait_gnt();
        chk("rand_gnt", gnt, 3'b100);
        chk("rand_cmd", mcmd, 10'h2AA);
        repeat (2) tick();
        req = 3'b101;
        tick();
        if (PREEMPT) begin
            chk("preempt_gnt", gnt, 3'b000);
            chk("preempt_ack", ack, 3'b000);
            chk("preempt_cmd", mcmd, 10'd0);
            wait_gnt();
            chk("preempt_esc_gnt", gnt, 3'b001);
        end else begin
            chk("nopreempt_gnt", gnt, 3'b100);
            chk("nopreempt_cmd", mcmd, 10'h2AA);
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("nopreempt_ack", ack, 3'b100);
            req = 3'b001;
            wait_gnt();
            chk("nopreempt_esc_gnt", gnt, 3'b001);
        end
        done = 1'b1;
        tick();
        done = 1'b0; req = 3'b000;
        repeat (4) tick();

        // Completion coinciding with withdrawal (and escape arrival).
        req = 3'b100;
        wait_gnt();
        repeat (2) tick();
        done = 1'b1;
        req = PREEMPT ? 3'b001 : 3'b000;
        tick();
        done = 1'b0;
        chk("same_cycle_ack", ack, 3'b100);
        chk("same_cycle_to", terr, 1'b0);
        req = 3'b000;
        repeat (5) tick();

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
            cmd0 = 10'($urandom); cmd1 = 10'($urandom); cmd2 = 10'($urandom);
            spd0 = 3'($urandom);  spd1 = 3'($urandom);  spd2 = 3'($urandom);
            done = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; done = 1'b0; req = '0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/motion_arbiter.md
# motion_arbiter

Shares the single Motion_Commands datapath among three motion requesters (bump escape, spiral, random walk). It grants one requester at a time and latches that requester's command and speed. It then drives them to Motion_Commands until `done_spin`, a timeout or an abort, and forces a STOP gap between grants. It sits between the move generators and Motion_Commands, replacing the combinational decision mux.

## Interface
Parameters:
- `TIMEOUT`, 4096: DRIVE cycles without `done_spin` before abort; range 2..65535.
- `GAP_CYCLES`, 2: STOP cycles inserted after every grant ends; range 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  3  requests: [0] escape, [1] spiral, [2] random; level, held until `ack` or withdrawn.
- `cmd0`, `cmd1`, `cmd2`  in  10  motion command per requester.
- `spd0`, `spd1`, `spd2`  in  3  speed per requester.
- `done_spin`  in  1  completion pulse from Motion_Commands.
- `gnt`  out  3  one-hot grant, held for all of DRIVE.
- `ack`  out  3  one-cycle completion pulse to the granted requester.
- `motion_command`  out  10  to Motion_Commands; 10'd0 = STOP.
- `motion_speed`  out  3  to Motion_Commands.
- `busy`  out  1  high in DRIVE and GAP.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, DRIVE, GAP. All outputs are registered.
- **IDLE**
  - Outputs: `motion_command`=0, `motion_speed`=0, `gnt`=0.
  - If `req`≠0, select a winner:
    - `req[0]` always wins.
    - Otherwise `req[1]`/`req[2]` are round-robin. `rr_last` (1 bit) records the last non-escape winner. When both request, the one not recorded in `rr_last` wins.
    - `rr_last` updates only when a non-escape requester is granted.
  - On a win: latch the winner's cmd/spd, set `gnt`, clear the watchdog and go to DRIVE.
- **DRIVE**
  - Outputs the latched cmd/spd. Input cmd/spd changes are ignored until the next grant.
  - Watchdog increments each cycle (16-bit, saturating).
  - Exit priority, highest first:
    1. `done_spin`=1: pulse `ack[winner]`.
    2. Preempt (see Configuration): abort, no `ack`.
    3. Winner's `req` deasserted: abort, no `ack`.
    4. Watchdog = `TIMEOUT`-1: pulse `timeout_err`, no `ack`.
  - Every exit clears `gnt` and goes to GAP.
- **GAP**
  - Outputs STOP with speed 0 for exactly `GAP_CYCLES` cycles, then returns to IDLE.
  - `req` is not sampled during GAP.
- `done_spin` in IDLE or GAP is ignored.
- An escape request is never round-robined. It waits only for the current grant to end (or preempts, if that feature is compiled in).
- Reset (asynchronous, any state): state=IDLE, `gnt`=0, `ack`=0, `motion_command`=0, `motion_speed`=0, `busy`=0, `timeout_err`=0, watchdog=0, `rr_last`=random (so spiral wins the first tie).

## Timing
- `req` sampled high in IDLE at edge k:
  - `gnt`, `busy`, `motion_command` and `motion_speed` are valid after edge k.
  - Request-to-drive latency is 1 cycle.
- `done_spin` sampled at edge m:
  - `ack` is high for the single cycle after edge m.
  - `motion_command`=0 and `gnt`=0 from the same edge.
- Timeout with grant at edge k:
  - `timeout_err` pulses after edge k+`TIMEOUT`.
  - STOP is output from that edge.
- GAP lasts `GAP_CYCLES` cycles. The earliest next grant is visible `GAP_CYCLES`+1 edges after the exit edge.
- Back-to-back throughput: one grant per (DRIVE length + `GAP_CYCLES` + 1) cycles.
- `ack` and `timeout_err` are never both high. At most one `ack` bit is high at a time.

## Configuration
- Macro: `MOTION_ARB_PREEMPT_EN`.
- Defined:
  - In DRIVE with winner ≠ escape, `req[0]`=1 aborts the grant: no `ack`, GAP, then escape wins in IDLE.
  - `done_spin` in the same cycle takes priority and produces the `ack`.
- Undefined:
  - No preemption. Escape waits for `done_spin`, withdraw or timeout of the current grant.

## Test plan
- **Reset mid-DRIVE:** grant spiral with cmd1=10'h155, assert `rst` asynchronously → all outputs 0 immediately. After release, `req`=3'b110 → `gnt`=3'b010 (spiral wins the first tie).
- **Round-robin:** `req`=3'b110 held and `done_spin` after 5 cycles each grant → successive `gnt` values 010, 100, 010, each followed by exactly `GAP_CYCLES`=2 STOP cycles.
- **Priority:** `req`=3'b111 in IDLE → `gnt`=3'b001, `motion_command`=cmd0, `motion_speed`=spd0. `ack`=3'b001 one cycle after `done_spin`.
- **Timeout:** `TIMEOUT`=16, no `done_spin` → `timeout_err` pulses 16 cycles after grant, `ack` stays 0, `motion_command`=0.
- **Preemption:** random (cmd2=10'h2AA) in DRIVE, raise `req[0]` →
  - With `MOTION_ARB_PREEMPT_EN`: abort next edge, no `ack[2]`, `gnt`=001 after GAP.
  - Without it: random continues until `done_spin`, then escape is granted.
- **Same-cycle events:** `done_spin` with `req[2]` dropping (and, with the macro defined, `req[0]` rising) in the same cycle → `ack`=3'b100, no abort.
